// File: rtl/conv_row_sequencer.sv
// Row sequencer for a convolution output feature map: issues one conv_start per
// output row, captures each returned row into its slot and pulses done after the last.
module conv_row_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  output logic                                       conv_start,
  input  logic                                       row_valid,
  input  logic [(W-F+1)*DATA_WIDTH-1:0]              row,
  output logic [5:0]                                 rowNumber,
  output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]      outputVector,
  output logic                                       busy,
  output logic                                       done
);

  localparam int ROWS     = H - F + 1;
  localparam int COLS     = W - F + 1;
  localparam int ROW_BITS = COLS * DATA_WIDTH;
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  // rowNumber is only 6 bits wide, so the map may not exceed 64 rows
  if (ROWS < 1 || ROWS > 64) begin : g_rows_check
    $error("conv_row_sequencer: H-F+1 must be in 1..64");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_r;

  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      rowNumber    <= 6'd0;
      conv_start   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      outputVector <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= S_ISSUE;
            rowNumber  <= 6'd0;
            conv_start <= 1'b1;
            busy       <= 1'b1;
          end else begin
            conv_start <= 1'b0;
            busy       <= 1'b0;
          end
        end
        S_ISSUE: begin
          conv_start <= 1'b0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (row_valid) begin
            // Only the slot matching the current row is written
            for (int r = 0; r < ROWS; r++) begin
              if (rowNumber == 6'(r)) begin
                outputVector[r*ROW_BITS +: ROW_BITS] <= row;
              end
            end
            if (rowNumber == LAST_ROW) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              rowNumber  <= rowNumber + 6'd1;
              state_r    <= S_ISSUE;
              conv_start <= 1'b1;
            end
          end else begin
            conv_start <= 1'b0;
          end
        end
        S_DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          conv_start <= 1'b0;
          rowNumber  <= 6'd0;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r    <= S_IDLE;
          rowNumber  <= 6'd0;
          conv_start <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
